// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the register-file family (integer, coprocessor and FP banks).
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package regfile_mp_pkg;

  // Default geometry: the classic 32 x 32-bit integer bank.
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Clear controller states; CLEAR is only reachable in sweep mode.
  typedef enum logic {
    ST_READY = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  // Number of entries addressed by an addr_w-bit register index.
  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Clear sequencer for regfile_mp: owns ready, the sweep counter and the dropped-write flag.
// Latency: ready/wr_err are registered; clr_* strobes are combinational for the current edge.
// Backpressure: ready=0 while a sweep runs or during reset; writes seen then raise wr_err.
module regfile_clear_ctrl
  import regfile_mp_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int CLEAR_MODE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  input  logic              reg_write_en,
  output logic              ready,
  output logic              wr_err,
  output logic              clr_all,
  output logic              clr_one,
  output logic [ADDR_W-1:0] clr_addr
);

  clr_state_t        state;
  clr_state_t        state_next;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_next;
  logic              ready_q;
  logic              last_entry;

  assign last_entry = (cnt == {ADDR_W{1'b1}});
  assign clr_addr   = cnt;

  // Parallel mode only needs a registered "out of reset" flag; sweep mode derives ready from the FSM.
  assign ready = (CLEAR_MODE != 0) ? (state == ST_READY) : ready_q;

  // Next-state logic and clear strobes to the storage array.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    clr_all    = 1'b0;
    clr_one    = 1'b0;
    if (CLEAR_MODE == 0) begin
      state_next = ST_READY;
      clr_all    = reset | (ready & clear_req);
    end else begin
      case (state)
        ST_READY: begin
          if (clear_req) begin
            state_next = ST_CLEAR;
            cnt_next   = '0;
          end
        end
        ST_CLEAR: begin
          // clear_req is deliberately not looked at here: a running sweep cannot be restarted by it.
          clr_one  = ~reset;
          cnt_next = cnt + ADDR_W'(1);
          if (last_entry) begin
            state_next = ST_READY;
          end
        end
        default: begin
          state_next = ST_CLEAR;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // State, counter and status flags; reset restarts any sweep from entry 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= (CLEAR_MODE != 0) ? ST_CLEAR : ST_READY;
      cnt     <= '0;
      ready_q <= 1'b0;
      wr_err  <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      ready_q <= 1'b1;
      wr_err  <= reg_write_en & ~ready;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with optional bypass, hard-wired $0 and clear sequencing.
// Latency: reads are combinational (same cycle); writes and clears commit at the next rising edge.
// Backpressure: ready=0 during reset/sweep; reads then return 0 and writes are dropped with wr_err.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int NUM_RD     = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1,
  parameter int CLEAR_MODE = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear_req,
  input  logic                     reg_write_en,
  input  logic [ADDR_W-1:0]        write_reg,
  input  logic [DATA_W-1:0]        write_data,
  input  logic [NUM_RD*ADDR_W-1:0] read_reg,
  output logic [NUM_RD*DATA_W-1:0] read_data,
  output logic                     ready,
  output logic                     wr_err
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              clr_all;
  logic              clr_one;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_commit;
  logic              wr_discard;

  regfile_clear_ctrl #(
    .ADDR_W     (ADDR_W),
    .CLEAR_MODE (CLEAR_MODE)
  ) u_clear_ctrl (
    .clk          (clk),
    .reset        (reset),
    .clear_req    (clear_req),
    .reg_write_en (reg_write_en),
    .ready        (ready),
    .wr_err       (wr_err),
    .clr_all      (clr_all),
    .clr_one      (clr_one),
    .clr_addr     (clr_addr)
  );

  // A clear request in the same cycle wins over the write, which is then dropped without wr_err.
  assign wr_commit  = reg_write_en & ready & ~clear_req & ~reset;
  assign wr_discard = (ZERO_REG != 0) && (write_reg == '0);

  // Storage update: bulk clear, single-entry sweep clear, or a normal write.
  always_ff @(posedge clk) begin
    if (clr_all) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clr_one) begin
      mem[clr_addr] <= '0;
    end else if (wr_commit && !wr_discard) begin
      mem[write_reg] <= write_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd_val;

    assign ra = read_reg[k*ADDR_W +: ADDR_W];

    // Read mux priority: hard-wired $0, then not-ready masking, then bypass, then storage.
    always_comb begin
      rd_val = mem[ra];
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rd_val = '0;
      end else if (!ready) begin
        rd_val = '0;
      end else if ((BYPASS != 0) && wr_commit && (write_reg == ra)) begin
        rd_val = write_data;
      end
    end

    assign read_data[k*DATA_W +: DATA_W] = rd_val;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default, no-bypass/no-$0 and sweep-clear instances.
// Latency: stimulus at posedge+1, outputs sampled at negedge.
// Backpressure: exercised through the sweep instance's ready/wr_err.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the two 32x32 instances (default and BYPASS=0/ZERO_REG=0).
  logic        rst, clr, we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [9:0]  rr;
  logic [63:0] rd_def, rd_nb;
  logic        rdy_def, rdy_nb, err_def, err_nb;

  // Sweep-mode instance, 8 entries, one read port.
  logic        rst_sw, clr_sw, we_sw;
  logic [2:0]  wa_sw, rr_sw;
  logic [31:0] wd_sw, rd_sw;
  logic        rdy_sw, err_sw;

  int n_pass = 0;
  int n_total = 0;

  regfile_mp u_def (
    .clk(clk), .reset(rst), .clear_req(clr), .reg_write_en(we),
    .write_reg(wa), .write_data(wd), .read_reg(rr), .read_data(rd_def),
    .ready(rdy_def), .wr_err(err_def)
  );

  regfile_mp #(.BYPASS(0), .ZERO_REG(0)) u_nb (
    .clk(clk), .reset(rst), .clear_req(clr), .reg_write_en(we),
    .write_reg(wa), .write_data(wd), .read_reg(rr), .read_data(rd_nb),
    .ready(rdy_nb), .wr_err(err_nb)
  );

  regfile_mp #(.ADDR_W(3), .NUM_RD(1), .CLEAR_MODE(1)) u_sw (
    .clk(clk), .reset(rst_sw), .clear_req(clr_sw), .reg_write_en(we_sw),
    .write_reg(wa_sw), .write_data(wd_sw), .read_reg(rr_sw), .read_data(rd_sw),
    .ready(rdy_sw), .wr_err(err_sw)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        clr;
    logic [31:0] e0_def;
    logic [31:0] e1_def;
    logic [31:0] e0_nb;
    logic [31:0] e1_nb;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // we, wa, wd, ra0, ra1, clr, exp p0/p1 default, exp p0/p1 no-bypass/no-$0
    vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
    vecs[1]  = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0};
    vecs[2]  = '{1'b1, 5'd7, 32'h1234,     5'd5, 5'd7, 1'b0, 32'hDEADBEEF, 32'h1234, 32'hDEADBEEF, 32'h0};
    vecs[3]  = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd7, 1'b0, 32'h1234, 32'h1234, 32'h1234, 32'h1234};
    vecs[4]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd5, 1'b0, 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
    vecs[5]  = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[6]  = '{1'b1, 5'd3, 32'hA5A5,     5'd3, 5'd9, 1'b0, 32'hA5A5, 32'h0, 32'h0, 32'h0};
    vecs[7]  = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd3, 1'b0, 32'hA5A5, 32'hA5A5, 32'hA5A5, 32'hA5A5};
    vecs[8]  = '{1'b1, 5'd9, 32'h5555,     5'd9, 5'd3, 1'b1, 32'h0, 32'hA5A5, 32'h0, 32'hA5A5};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd9, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[10] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd7, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[11] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};

    rst = 1'b1; clr = 1'b0; we = 1'b0; wa = '0; wd = '0; rr = {5'd0, 5'd5};
    rst_sw = 1'b1; clr_sw = 1'b0; we_sw = 1'b0; wa_sw = '0; wd_sw = '0; rr_sw = 3'd2;

    // Reset state.
    cyc();
    @(negedge clk);
    chk("reset_ready_def", 64'(rdy_def), 64'd0);
    chk("reset_wr_err_def", 64'(err_def), 64'd0);
    chk("reset_read_def", rd_def, 64'd0);
    chk("reset_ready_sw", 64'(rdy_sw), 64'd0);
    chk("reset_wr_err_sw", 64'(err_sw), 64'd0);
    cyc();
    rst = 1'b0;
    rst_sw = 1'b0;

    // Power-up sweep: ready low for exactly 8 cycles; write in cycle 3 dropped, wr_err in cycle 4.
    for (int c = 1; c <= 8; c++) begin
      we_sw = (c == 3);
      wa_sw = 3'd2;
      wd_sw = 32'h77;
      @(negedge clk);
      chk($sformatf("sweep_ready_c%0d", c), 64'(rdy_sw), 64'd0);
      chk($sformatf("sweep_wr_err_c%0d", c), 64'(err_sw), 64'(c == 4));
      if (c >= 2) chk($sformatf("def_ready_c%0d", c), 64'(rdy_def), 64'd1);
      cyc();
    end
    we_sw = 1'b0;
    @(negedge clk);
    chk("sweep_ready_done", 64'(rdy_sw), 64'd1);
    chk("sweep_wr_err_done", 64'(err_sw), 64'd0);
    chk("sweep_dropped_write", 64'(rd_sw), 64'd0);

    // Normal write with bypass in the sweep instance.
    cyc();
    we_sw = 1'b1; wa_sw = 3'd2; wd_sw = 32'h77;
    @(negedge clk);
    chk("sw_bypass", 64'(rd_sw), 64'h77);
    cyc();
    we_sw = 1'b0;
    @(negedge clk);
    chk("sw_stored", 64'(rd_sw), 64'h77);

    // clear_req starts a sweep; reset during sweep cycle 5 restarts it.
    cyc();
    clr_sw = 1'b1;
    @(negedge clk);
    chk("clr_req_ready", 64'(rdy_sw), 64'd1);
    cyc();
    clr_sw = 1'b0;
    for (int s = 1; s <= 4; s++) begin
      @(negedge clk);
      chk($sformatf("clr_sweep_ready_s%0d", s), 64'(rdy_sw), 64'd0);
      if (s == 1) chk("clr_sweep_read_masked", 64'(rd_sw), 64'd0);
      cyc();
    end
    rst_sw = 1'b1;
    we_sw = 1'b1;
    @(negedge clk);
    chk("midsweep_reset_ready", 64'(rdy_sw), 64'd0);
    cyc();
    rst_sw = 1'b0;
    we_sw = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk($sformatf("restart_ready_c%0d", c), 64'(rdy_sw), 64'd0);
      if (c == 1) chk("reset_write_no_err", 64'(err_sw), 64'd0);
      cyc();
    end
    @(negedge clk);
    chk("restart_ready_done", 64'(rdy_sw), 64'd1);
    chk("restart_cleared", 64'(rd_sw), 64'd0);

    // Table-driven vectors on the two parallel-clear instances.
    cyc();
    for (int i = 0; i < 12; i++) begin
      we  = vecs[i].we;
      wa  = vecs[i].wa;
      wd  = vecs[i].wd;
      rr  = {vecs[i].ra1, vecs[i].ra0};
      clr = vecs[i].clr;
      @(negedge clk);
      chk($sformatf("v%0d_def_p0", i), 64'(rd_def[31:0]), 64'(vecs[i].e0_def));
      chk($sformatf("v%0d_def_p1", i), 64'(rd_def[63:32]), 64'(vecs[i].e1_def));
      chk($sformatf("v%0d_nb_p0", i), 64'(rd_nb[31:0]), 64'(vecs[i].e0_nb));
      chk($sformatf("v%0d_nb_p1", i), 64'(rd_nb[63:32]), 64'(vecs[i].e1_nb));
      chk($sformatf("v%0d_ready", i), {62'd0, rdy_def, rdy_nb}, 64'd3);
      chk($sformatf("v%0d_wr_err", i), {62'd0, err_def, err_nb}, 64'd0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
